// File: rtl/select_sched_pkg.sv
// rtl/select_sched_pkg.sv - shared constants and state type for the select scheduler
// Holds default parameter values, the FSM state encoding and the o_err bit indices.
package select_sched_pkg;

  localparam int DEF_NUM_PORTS   = 5;
  localparam int DEF_CREDIT_W    = 3;
  localparam int DEF_MAX_CREDIT  = 4;
  localparam int DEF_TIMEOUT_W   = 8;
  localparam int DEF_TIMEOUT_CYC = 200;

  localparam int GRANT_IDX_W = 3;
  localparam int ERR_W       = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_FREE = 2'd2,
    ERR       = 2'd3
  } state_e;

  localparam int ERR_TO   = 0;
  localparam int ERR_SPUR = 1;
  localparam int ERR_OVF  = 2;

endpackage

// File: rtl/select_sched_if.sv
// rtl/select_sched_if.sv - token, selector and status signals of the select scheduler
// slave : scheduler side (inputs i_*, outputs o_*)
// master: requester / selector / bench side (drives i_*, observes o_*)
interface select_sched_if
  import select_sched_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) ();

  logic                   i_pkt_valid;
  logic [NUM_PORTS-1:0]   i_pkt_mask;
  logic                   o_pkt_ack;
  logic [GRANT_IDX_W-1:0] o_grant_idx;
  logic [NUM_PORTS-1:0]   o_select;
  logic                   o_drive;
  logic                   i_free;
  logic [NUM_PORTS-1:0]   i_credit_ret;
  logic                   i_err_clr;
  logic                   o_busy;
  logic [ERR_W-1:0]       o_err;

  modport slave (
    input  i_pkt_valid, i_pkt_mask, i_free, i_credit_ret, i_err_clr,
    output o_pkt_ack, o_grant_idx, o_select, o_drive, o_busy, o_err
  );

  modport master (
    output i_pkt_valid, i_pkt_mask, i_free, i_credit_ret, i_err_clr,
    input  o_pkt_ack, o_grant_idx, o_select, o_drive, o_busy, o_err
  );

endinterface

// File: rtl/select_sched_rr_pick_onehot.sv
// rtl/select_sched_rr_pick_onehot.sv - combinational round-robin picker
// req     : request vector
// ptr     : index searched first; search wraps modulo N
// gnt     : one-hot grant (all zero when nothing requests)
// idx     : index of the granted bit
// any_req : at least one request present
module rr_pick_onehot #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    pos     = '0;
    for (int off = 0; off < N; off++) begin
      pos = IDX_W'((int'(ptr) + off) % N);
      if (!any_req && req[pos]) begin
        any_req = 1'b1;
        idx     = pos;
      end
    end
    gnt[idx] = any_req;
  end

endmodule

// File: rtl/select_sched.sv
// rtl/select_sched.sv - round-robin, credit-gated scheduler driving a click-based selector
// clk, rstn : clock and asynchronous active-low reset
// bus       : token request/ack, one-hot select + drive pulse, free return,
//             per-port credit returns, error clear, busy and sticky error flags
module select_sched
  import select_sched_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int CREDIT_W    = DEF_CREDIT_W,
  parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic          clk,
  input logic          rstn,
  select_sched_if.slave bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   select_q, select_d;
  logic                   drive_q, drive_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [GRANT_IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [ERR_W-1:0]       err_evt;
  logic [CREDIT_W-1:0]    credit_q [NUM_PORTS];
  logic [CREDIT_W-1:0]    credit_d [NUM_PORTS];

  logic [NUM_PORTS-1:0]   elig;
  logic [NUM_PORTS-1:0]   pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   do_grant;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = bus.i_pkt_mask[i] & (credit_q[i] != '0);
    end
  end

  rr_pick_onehot #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    drive_d     = 1'b0;
    ack_d       = 1'b0;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    wd_d        = wd_q;
    err_evt     = '0;
    do_grant    = 1'b0;

    case (state_q)
      IDLE: begin
        select_d = '0;
        if (bus.i_free) begin
          err_evt[ERR_SPUR] = 1'b1;
        end
        if (bus.i_pkt_valid && pick_any) begin
          do_grant    = 1'b1;
          state_d     = ISSUE;
          select_d    = pick_gnt;
          drive_d     = 1'b1;
          ack_d       = 1'b1;
          grant_idx_d = GRANT_IDX_W'(pick_idx);
          ptr_d       = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      ISSUE: begin
        wd_d = '0;
        // A fast selector may already return free during the launch cycle.
        if (bus.i_free) begin
          state_d  = IDLE;
          select_d = '0;
        end else begin
          state_d = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        // Free takes priority over a timeout landing in the same cycle.
        if (bus.i_free) begin
          state_d  = IDLE;
          select_d = '0;
        end else if (wd_q == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
          state_d         = ERR;
          select_d        = '0;
          err_evt[ERR_TO] = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ERR: begin
        select_d = '0;
        if (bus.i_err_clr) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = '0;
      end
    endcase

    // A grant and a return on the same port cancel; a lone return at the
    // ceiling saturates and is reported as overflow.
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit_d[i] = credit_q[i];
      if (do_grant && pick_gnt[i]) begin
        if (!bus.i_credit_ret[i]) begin
          credit_d[i] = credit_q[i] - 1'b1;
        end
      end else if (bus.i_credit_ret[i]) begin
        if (credit_q[i] == CREDIT_W'(MAX_CREDIT)) begin
          err_evt[ERR_OVF] = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] + 1'b1;
        end
      end
    end

    // New events win over a simultaneous clear.
    err_d  = (bus.i_err_clr ? '0 : err_q) | err_evt;
    busy_d = (state_d == ISSUE) || (state_d == WAIT_FREE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      select_q    <= '0;
      drive_q     <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      wd_q        <= '0;
      err_q       <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        credit_q[i] <= CREDIT_W'(MAX_CREDIT);
      end
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      drive_q     <= drive_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      credit_q    <= credit_d;
    end
  end

  assign bus.o_select    = select_q;
  assign bus.o_drive     = drive_q;
  assign bus.o_pkt_ack   = ack_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_grant_idx = grant_idx_q;
  assign bus.o_err       = err_q;

endmodule
